alu_wb_sequencer: RTL
=====================

# alu_wb_sequencer

Multi-cycle execute/writeback sequencer that sits directly around the 16×32 register file. It accepts one register-to-register instruction at a time over a valid/ready handshake and drives the file's read addresses. It captures the two operands, computes the result (single-step ALU ops, or an optional 32-cycle shift-add multiply), then drives the file's write port for exactly one clock cycle. It is the register file's only writer.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 4-bit register index.

Ports:
- clk  in  1  — single clock; the register file writes on its falling edge.
- rst_n  in  1  — synchronous reset, active low, sampled on the rising edge of clk.
- in_valid  in  1  — instruction offered.
- in_ready  out  1  — sequencer idle; an instruction is accepted when in_valid && in_ready at a rising edge.
- in_op  in  4  — opcode.
- in_rs1, in_rs2, in_rd  in  4 each  — source and destination indices.
- RN1, RN2  out  4 each  — register file read addresses.
- RD1, RD2  in  32 each  — register file read data, combinational from RN1/RN2.
- EnRW  out  1  — register file write enable.
- WN  out  4  — write index.
- WD  out  32  — write data.
- done  out  1  — one-cycle pulse, coincident with the WB cycle or the illegal-op cycle.
- illegal  out  1  — one-cycle pulse for an unsupported opcode.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: modulo 2^32, with no flags.
  - 5 SLL, 6 SRL: logical shift; the amount is opb[4:0].
  - 7 MUL: low 32 bits of the unsigned product.
  - 8–15: illegal.
- FSM states: IDLE, READ, EXEC, MUL, WB.
  - IDLE: in_ready=1. On accept, latch op/rs1/rs2/rd → READ.
  - READ: RN1=rs1, RN2=rs2. At the closing edge, capture RD1/RD2 into opa/opb → EXEC.
  - EXEC, ALU op: result register ← f(opa, opb) → WB.
  - EXEC, MUL: load multiplicand, multiplier and accumulator; clear the 5-bit counter → MUL.
  - EXEC, illegal op: pulse illegal and done; no write → IDLE.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand. Then shift the multiplicand left 1 and the multiplier right 1. After the 32nd iteration (counter wraps from 31) → WB with result=acc.
  - WB: EnRW=1, WN=rd, WD=result, done=1 → IDLE.
- rd=0 still produces a normal WB cycle; the register file discards the write.
- RN1/RN2 hold their last values outside READ.
- in_* inputs are ignored while in_ready=0.

## Timing
- Reset values: state IDLE, in_ready=1, RN1=RN2=0, EnRW=0, WN=0, WD=0, done=0, illegal=0, opa=opb=result=0.
- EnRW, WN, WD, done and illegal are registered outputs.
- Accept at edge T0 → READ during cycle T0–T1 → EXEC during T1–T2 → WB during T2–T3. The write commits at the falling edge inside WB. in_ready rises after T3.
- Latency:
  - ALU ops: 4 cycles accept-to-accept.
  - MUL: READ + EXEC + 32 MUL + WB, so 36 cycles accept-to-accept.
  - Illegal op: 3 cycles.
- Back-to-back dependent instructions need no forwarding. The WB write lands at the negedge before the next READ.
- Reset mid-operation: the FSM returns to IDLE and EnRW clears at the first rising edge with rst_n=0. A write whose negedge precedes that edge completes; no later write occurs.
- in_valid asserted during reset is not accepted. Acceptance is possible from the first edge with rst_n=1.

## Configuration
- `ALU_WB_MUL_EN` defined: opcode 7 runs the iterative multiplier as described.
- `ALU_WB_MUL_EN` undefined:
  - The MUL state and the multiplier datapath are removed.
  - Opcode 7 is treated as illegal: illegal/done pulse after 3 cycles, no write.

## Structure
- Shared package alu_wb_pkg holds:
  - the opcode localparams (OP_ADD…OP_MUL);
  - the state enumeration typedef;
  - the 32-bit data and 4-bit index typedefs.
- Sub-module seq_multiplier holds the shift-add datapath and counter, with start/busy/done and a 32-bit product. It is instantiated only under `ALU_WB_MUL_EN`.

## Test plan
Register file initial contents: r1=0x00016326, r2=5, r4=0x000FE331, r5=0x00045432.
- ADD r6=r4+r5 → one WB cycle with WN=6, WD=0x00143763. in_ready is low for exactly 3 cycles after accept.
- SUB r8=r2−r1 → WD=0xFFFE9CDF (wrap-around).
- SLL r9=r2<<r2, followed immediately by ADD r10=r9+r2 → WD=0x000000A0, then WD=0x000000A5 (no hazard).
- MUL r3=r1×r2, with the macro defined → WD=0x0006EFBE, 36 cycles accept-to-accept. With the macro undefined → illegal pulse, EnRW never asserted.
- Illegal opcode 12 → illegal=done=1 for one cycle, no write. Separately, ADD with rd=0 → EnRW=1 with WN=0, and r0 stays 0.
- rst_n low during the 10th MUL cycle → IDLE and in_ready=1 after reset; EnRW never asserted and r3 unchanged.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared opcodes, state encoding, datapath types and ALU helper for alu_wb_sequencer.
// `ALU_WB_MUL_EN adds the MUL state and makes opcode 7 legal.
package alu_wb_pkg;

  typedef logic [31:0] data_t;
  typedef logic [3:0]  idx_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

`ifdef ALU_WB_MUL_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
`endif

  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_WB_MUL_EN
    return op <= OP_MUL;
`else
    return op < OP_MUL;
`endif
  endfunction

  // Single-step ops only; MUL goes through seq_multiplier.
  function automatic data_t alu_f(input logic [3:0] op, input data_t a, input data_t b);
    data_t r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// 32-iteration shift-add multiplier, low 32 bits of the unsigned product.
// done/product are combinational during the final iteration so the caller can register them.
module seq_multiplier
  import alu_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplier_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  data_t      mcand;
  data_t      mplier;
  data_t      acc;
  logic [4:0] cnt;

  // Accumulator value after the current iteration.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_wb_sequencer.sv
// Execute/writeback sequencer and sole writer of the 16x32 register file; `ALU_WB_MUL_EN enables MUL.
// Latency accept-to-accept: 4 cycles ALU, 36 MUL, 3 illegal; one-cycle registered write/done pulse.
// Backpressure: in_ready is high only in IDLE; in_* are ignored otherwise.
module alu_wb_sequencer
  import alu_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  output logic [3:0]  RN1,
  output logic [3:0]  RN2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        EnRW,
  output logic [3:0]  WN,
  output logic [31:0] WD,
  output logic        done,
  output logic        illegal
);

  state_t     state, state_d;
  logic [3:0] op;
  idx_t       rd;
  data_t      opa, opb;

  logic       enrw_d, done_d, illegal_d;
  idx_t       wn_d;
  data_t      wd_d;

`ifdef ALU_WB_MUL_EN
  logic       mul_start, mul_busy, mul_done;
  data_t      mul_product;

  seq_multiplier u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .mcand_in  (opa),
    .mplier_in (opb),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );
`endif

  assign in_ready = (state == S_IDLE);

  always_comb begin
    state_d   = state;
    enrw_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    wn_d      = WN;
    wd_d      = WD;
`ifdef ALU_WB_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      S_IDLE: if (in_valid) state_d = S_READ;
      S_READ: begin
        state_d = S_EXEC;
        // Registered pulse lands in the EXEC cycle of an unsupported opcode.
        if (!op_legal(op)) begin
          illegal_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      S_EXEC: begin
        if (!op_legal(op)) begin
          state_d = S_IDLE;
`ifdef ALU_WB_MUL_EN
        end else if (op == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = S_MUL;
`endif
        end else begin
          state_d = S_WB;
          enrw_d  = 1'b1;
          done_d  = 1'b1;
          wn_d    = rd;
          wd_d    = alu_f(op, opa, opb);
        end
      end
`ifdef ALU_WB_MUL_EN
      S_MUL: begin
        if (!mul_busy) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          state_d = S_WB;
          enrw_d  = 1'b1;
          done_d  = 1'b1;
          wn_d    = rd;
          wd_d    = mul_product;
        end
      end
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op      <= '0;
      rd      <= '0;
      RN1     <= '0;
      RN2     <= '0;
      opa     <= '0;
      opb     <= '0;
      EnRW    <= 1'b0;
      WN      <= '0;
      WD      <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_d;
      EnRW    <= enrw_d;
      WN      <= wn_d;
      WD      <= wd_d;
      done    <= done_d;
      illegal <= illegal_d;
      // Read addresses load at accept and then hold until the next accept.
      if (state == S_IDLE && in_valid) begin
        op  <= in_op;
        rd  <= in_rd;
        RN1 <= in_rs1;
        RN2 <= in_rs2;
      end
      if (state == S_READ) begin
        opa <= RD1;
        opb <= RD2;
      end
    end
  end

endmodule
